// File: rtl/alu_result_checker_if.sv
// Bus between the ALU stimulus/response path and alu_result_checker.
//   master: drives start, in_valid, op_a, op_b, opcode, dut_result; observes results
//   slave : the checker; consumes stimulus and ALU result, drives status and statistics
//   start/in_valid/op_a/op_b/opcode : run control and the vector applied to the ALU
//   dut_result                      : 9-bit ALU result
//   busy/done/pass                  : run status
//   err_count/check_count           : run statistics
//   first_err_idx/exp/got           : first mismatch capture
interface alu_result_checker_if #(
    parameter int unsigned ERR_CNT_W = 8
);
    logic                 start;
    logic                 in_valid;
    logic [7:0]           op_a;
    logic [7:0]           op_b;
    logic [1:0]           opcode;
    logic [8:0]           dut_result;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_CNT_W-1:0] err_count;
    logic [8:0]           check_count;
    logic [7:0]           first_err_idx;
    logic [8:0]           first_err_exp;
    logic [8:0]           first_err_got;

    modport master (
        output start, in_valid, op_a, op_b, opcode, dut_result,
        input  busy, done, pass, err_count, check_count,
               first_err_idx, first_err_exp, first_err_got
    );

    modport slave (
        input  start, in_valid, op_a, op_b, opcode, dut_result,
        output busy, done, pass, err_count, check_count,
               first_err_idx, first_err_exp, first_err_got
    );
endinterface

// File: rtl/alu_result_checker.sv
// Self-checking response monitor for simple_alu. Recomputes the expected ALU result from the
// applied vector, delays it by LATENCY cycles, compares it with the ALU output and keeps
// pass/fail statistics plus a capture of the first mismatch.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : alu_result_checker_if.slave (stimulus, ALU result, status and statistics)
module alu_result_checker #(
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned VEC_COUNT = 256,
    parameter int unsigned ERR_CNT_W = 8
) (
    input logic                  clk,
    input logic                  reset,
    alu_result_checker_if.slave  bus
);

    localparam logic [8:0]           VecCountW = 9'(VEC_COUNT);
    localparam logic [ERR_CNT_W-1:0] ErrMax    = '1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [8:0]           accepted_q, accepted_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic [8:0]           check_count_q, check_count_d;
    logic [7:0]           first_err_idx_q, first_err_idx_d;
    logic [8:0]           first_err_exp_q, first_err_exp_d;
    logic [8:0]           first_err_got_q, first_err_got_d;
    logic                 busy_q, done_q;

    logic [LATENCY-1:0]       pipe_vld_q;
    logic [LATENCY-1:0][8:0]  pipe_exp_q;
    logic [LATENCY-1:0][7:0]  pipe_idx_q;

    logic       clear_run;
    logic       push;
    logic       exit_vld;
    logic       mismatch;
    logic [8:0] expected;

    function automatic logic [8:0] golden(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
        logic [8:0] r;
        unique case (op)
            2'b00: r = {1'b0, a} + {1'b0, b};
            2'b01: r = {1'b0, a} - {1'b0, b};
            2'b10: r = {1'b0, a & b};
            2'b11: r = {1'b0, a | b};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign expected = golden(bus.op_a, bus.op_b, bus.opcode);
    assign push     = (state_q == StRun) && bus.in_valid && (accepted_q < VecCountW);
    assign exit_vld = (state_q == StRun) && pipe_vld_q[LATENCY-1];
    assign mismatch = exit_vld && (pipe_exp_q[LATENCY-1] != bus.dut_result);

    always_comb begin
        state_d         = state_q;
        accepted_d      = accepted_q;
        err_count_d     = err_count_q;
        check_count_d   = check_count_q;
        first_err_idx_d = first_err_idx_q;
        first_err_exp_d = first_err_exp_q;
        first_err_got_d = first_err_got_q;
        clear_run       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    clear_run = 1'b1;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (push) begin
                    accepted_d = accepted_q + 9'd1;
                end
                if (exit_vld) begin
                    check_count_d = check_count_q + 9'd1;
                    if (mismatch) begin
                        if (err_count_q == '0) begin
                            first_err_idx_d = pipe_idx_q[LATENCY-1];
                            first_err_exp_d = pipe_exp_q[LATENCY-1];
                            first_err_got_d = bus.dut_result;
                        end
                        if (err_count_q != ErrMax) begin
                            err_count_d = err_count_q + ERR_CNT_W'(1);
                        end
                    end
                    if (check_count_q + 9'd1 == VecCountW) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (bus.start) begin
                    clear_run = 1'b1;
                    state_d   = StRun;
                end
            end
            default: state_d = StIdle;
        endcase

        // Entering RUN starts the run from a clean slate; nothing is accepted on this edge.
        if (clear_run) begin
            accepted_d      = '0;
            err_count_d     = '0;
            check_count_d   = '0;
            first_err_idx_d = '0;
            first_err_exp_d = '0;
            first_err_got_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            accepted_q      <= '0;
            err_count_q     <= '0;
            check_count_q   <= '0;
            first_err_idx_q <= '0;
            first_err_exp_q <= '0;
            first_err_got_q <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            accepted_q      <= accepted_d;
            err_count_q     <= err_count_d;
            check_count_q   <= check_count_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_exp_q <= first_err_exp_d;
            first_err_got_q <= first_err_got_d;
            busy_q          <= (state_d == StRun);
            done_q          <= (state_d == StDone);
        end
    end

    // Bubble-tolerant delay line: an invalid cycle shifts through as a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld_q <= '0;
            pipe_exp_q <= '0;
            pipe_idx_q <= '0;
        end else if (clear_run) begin
            pipe_vld_q <= '0;
            pipe_exp_q <= '0;
            pipe_idx_q <= '0;
        end else begin
            pipe_vld_q[0] <= push;
            pipe_exp_q[0] <= expected;
            pipe_idx_q[0] <= accepted_q[7:0];
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_exp_q[i] <= pipe_exp_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = done_q && (err_count_q == '0);
    assign bus.err_count     = err_count_q;
    assign bus.check_count   = check_count_q;
    assign bus.first_err_idx = first_err_idx_q;
    assign bus.first_err_exp = first_err_exp_q;
    assign bus.first_err_got = first_err_got_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker. Five checker instances with different parameters
// share one stimulus stream; only the instance that has been started reacts to it. The ALU
// itself is modelled by delaying a hand-computed (optionally corrupted) result by 1 or 3 cycles.
module tb_alu_result_checker;

    logic       clk;
    logic       reset;
    logic [4:0] start_v;
    logic       in_valid;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [1:0] opcode;
    logic [8:0] alu_val;
    logic [8:0] d1, d2, d3;
    logic [4:0] done_v;

    int n_checks = 0;
    int n_errors = 0;

    alu_result_checker_if #(.ERR_CNT_W(8)) if_a ();
    alu_result_checker_if #(.ERR_CNT_W(8)) if_b ();
    alu_result_checker_if #(.ERR_CNT_W(2)) if_c ();
    alu_result_checker_if #(.ERR_CNT_W(8)) if_d ();
    alu_result_checker_if #(.ERR_CNT_W(8)) if_e ();

    alu_result_checker #(.LATENCY(1), .VEC_COUNT(4), .ERR_CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .bus(if_a));
    alu_result_checker #(.LATENCY(1), .VEC_COUNT(8), .ERR_CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .bus(if_b));
    alu_result_checker #(.LATENCY(1), .VEC_COUNT(6), .ERR_CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .bus(if_c));
    alu_result_checker #(.LATENCY(3), .VEC_COUNT(4), .ERR_CNT_W(8)) u_d (
        .clk(clk), .reset(reset), .bus(if_d));
    alu_result_checker #(.LATENCY(1), .VEC_COUNT(256), .ERR_CNT_W(8)) u_e (
        .clk(clk), .reset(reset), .bus(if_e));

    assign if_a.start = start_v[0];
    assign if_b.start = start_v[1];
    assign if_c.start = start_v[2];
    assign if_d.start = start_v[3];
    assign if_e.start = start_v[4];

    assign if_a.in_valid = in_valid;
    assign if_b.in_valid = in_valid;
    assign if_c.in_valid = in_valid;
    assign if_d.in_valid = in_valid;
    assign if_e.in_valid = in_valid;
    assign if_a.op_a = op_a;
    assign if_b.op_a = op_a;
    assign if_c.op_a = op_a;
    assign if_d.op_a = op_a;
    assign if_e.op_a = op_a;
    assign if_a.op_b = op_b;
    assign if_b.op_b = op_b;
    assign if_c.op_b = op_b;
    assign if_d.op_b = op_b;
    assign if_e.op_b = op_b;
    assign if_a.opcode = opcode;
    assign if_b.opcode = opcode;
    assign if_c.opcode = opcode;
    assign if_d.opcode = opcode;
    assign if_e.opcode = opcode;
    assign if_a.dut_result = d1;
    assign if_b.dut_result = d1;
    assign if_c.dut_result = d1;
    assign if_d.dut_result = d3;
    assign if_e.dut_result = d1;

    assign done_v = {if_e.done, if_d.done, if_c.done, if_b.done, if_a.done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: result of the vector applied at edge N appears from edge N+1 (d1) or N+3 (d3).
    always @(posedge clk) begin
        d1 <= alu_val;
        d2 <= d1;
        d3 <= d2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic [8:0] res);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        opcode   = op;
        alu_val  = res;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int sel);
        start_v      = '0;
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v      = '0;
    endtask

    task automatic wait_done(input string tag, input int sel, input int budget);
        for (int i = 0; i < budget && !done_v[sel]; i++) @(negedge clk);
        check(tag, 32'(done_v[sel]), 32'd1);
    endtask

    task automatic check_a_cleared(input string tag);
        check({tag, "_busy"}, 32'(if_a.busy), 32'd0);
        check({tag, "_done"}, 32'(if_a.done), 32'd0);
        check({tag, "_pass"}, 32'(if_a.pass), 32'd0);
        check({tag, "_err"}, 32'(if_a.err_count), 32'd0);
        check({tag, "_chk"}, 32'(if_a.check_count), 32'd0);
        check({tag, "_fidx"}, 32'(if_a.first_err_idx), 32'd0);
        check({tag, "_fexp"}, 32'(if_a.first_err_exp), 32'd0);
        check({tag, "_fgot"}, 32'(if_a.first_err_got), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        start_v  = '0;
        in_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        opcode   = '0;
        alu_val  = '0;
        repeat (3) @(negedge clk);
        check_a_cleared("rst");
        check("rst_d_busy", 32'(if_d.busy), 32'd0);
        // start coincident with reset: reset must win
        start_v = 5'b00001;
        @(negedge clk);
        start_v = '0;
        check("rst_start_busy", 32'(if_a.busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // All-correct run
        pulse_start(0);
        check("t1_busy", 32'(if_a.busy), 32'd1);
        send(8'h05, 8'h03, 2'b00, 9'h008);
        send(8'h05, 8'h03, 2'b01, 9'h002);
        send(8'hF0, 8'h3C, 2'b10, 9'h030);
        send(8'hF0, 8'h0F, 2'b11, 9'h0FF);
        idle(0);
        wait_done("t1_done", 0, 10);
        check("t1_pass", 32'(if_a.pass), 32'd1);
        check("t1_err", 32'(if_a.err_count), 32'd0);
        check("t1_chk", 32'(if_a.check_count), 32'd4);
        check("t1_busy_low", 32'(if_a.busy), 32'd0);

        // Carry and borrow, restarted from DONE
        pulse_start(0);
        check("t2_chk_clr", 32'(if_a.check_count), 32'd0);
        send(8'hFF, 8'hFF, 2'b00, 9'h1FE);
        send(8'h00, 8'h01, 2'b01, 9'h1FF);
        send(8'hFF, 8'h01, 2'b00, 9'h100);
        send(8'hAA, 8'h55, 2'b11, 9'h0FF);
        idle(0);
        wait_done("t2_done", 0, 10);
        check("t2_pass", 32'(if_a.pass), 32'd1);
        check("t2_chk", 32'(if_a.check_count), 32'd4);

        // Injected error on vector 3
        pulse_start(1);
        send(8'h10, 8'h01, 2'b00, 9'h011);
        send(8'h20, 8'h02, 2'b00, 9'h022);
        send(8'h80, 8'h80, 2'b00, 9'h100);
        send(8'hAA, 8'hFF, 2'b10, 9'h000);  // expected 0x0AA
        send(8'h0F, 8'h01, 2'b01, 9'h00E);
        send(8'h03, 8'h05, 2'b01, 9'h1FE);
        send(8'hC3, 8'h3C, 2'b11, 9'h0FF);
        send(8'h12, 8'h34, 2'b00, 9'h046);
        idle(0);
        wait_done("t3_done", 1, 10);
        check("t3_err", 32'(if_b.err_count), 32'd1);
        check("t3_fidx", 32'(if_b.first_err_idx), 32'd3);
        check("t3_fexp", 32'(if_b.first_err_exp), 32'h0AA);
        check("t3_fgot", 32'(if_b.first_err_got), 32'h000);
        check("t3_pass", 32'(if_b.pass), 32'd0);
        check("t3_chk", 32'(if_b.check_count), 32'd8);

        // Saturation: 2-bit error counter, every result wrong (expected i+1, fed i+2)
        pulse_start(2);
        for (int i = 0; i < 6; i++) send(8'(i), 8'h01, 2'b00, 9'(i + 2));
        idle(0);
        wait_done("t4_done", 2, 10);
        check("t4_err", 32'(if_c.err_count), 32'd3);
        check("t4_pass", 32'(if_c.pass), 32'd0);
        check("t4_fidx", 32'(if_c.first_err_idx), 32'd0);
        check("t4_fexp", 32'(if_c.first_err_exp), 32'h001);
        check("t4_fgot", 32'(if_c.first_err_got), 32'h002);
        check("t4_chk", 32'(if_c.check_count), 32'd6);

        // Latency 3 with bubbles of 0, 2 and 1 cycles
        pulse_start(3);
        send(8'h05, 8'h03, 2'b00, 9'h008);
        send(8'h05, 8'h03, 2'b01, 9'h002);
        idle(2);
        send(8'hF0, 8'h3C, 2'b10, 9'h030);
        idle(1);
        send(8'hF0, 8'h0F, 2'b11, 9'h0FF);
        idle(2);
        check("t5_pre_busy", 32'(if_d.busy), 32'd1);
        check("t5_pre_done", 32'(if_d.done), 32'd0);
        check("t5_pre_chk", 32'(if_d.check_count), 32'd3);
        @(negedge clk);
        check("t5_done", 32'(if_d.done), 32'd1);
        check("t5_busy", 32'(if_d.busy), 32'd0);
        check("t5_chk", 32'(if_d.check_count), 32'd4);
        check("t5_pass", 32'(if_d.pass), 32'd1);

        // 256 vectors: a | 0 = a, last one corrupted
        pulse_start(4);
        for (int i = 0; i < 256; i++) begin
            send(8'(i), 8'h00, 2'b11, (i == 255) ? 9'h000 : 9'(i));
        end
        idle(0);
        wait_done("t6_done", 4, 10);
        check("t6_chk", 32'(if_e.check_count), 32'd256);
        check("t6_err", 32'(if_e.err_count), 32'd1);
        check("t6_fidx", 32'(if_e.first_err_idx), 32'd255);
        check("t6_fexp", 32'(if_e.first_err_exp), 32'h0FF);
        check("t6_fgot", 32'(if_e.first_err_got), 32'h000);
        check("t6_pass", 32'(if_e.pass), 32'd0);
        send(8'h01, 8'h01, 2'b00, 9'h000);
        idle(2);
        check("t6_hold_chk", 32'(if_e.check_count), 32'd256);
        check("t6_hold_done", 32'(if_e.done), 32'd1);

        // Reset mid-run, stray vectors before start, then a clean run
        pulse_start(0);
        send(8'h01, 8'h02, 2'b00, 9'h003);
        send(8'h07, 8'h02, 2'b01, 9'h005);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check_a_cleared("t7_rst");
        check("t7_e_done", 32'(if_e.done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        send(8'h01, 8'h01, 2'b00, 9'h002);
        send(8'h02, 8'h02, 2'b00, 9'h004);
        idle(2);
        check("t7_stray_busy", 32'(if_a.busy), 32'd0);
        check("t7_stray_chk", 32'(if_a.check_count), 32'd0);
        pulse_start(0);
        send(8'h33, 8'h11, 2'b00, 9'h044);
        send(8'h33, 8'h44, 2'b01, 9'h1EF);
        send(8'h3C, 8'h0F, 2'b10, 9'h00C);
        send(8'h30, 8'h03, 2'b11, 9'h033);
        idle(0);
        wait_done("t7_done", 0, 10);
        check("t7_pass", 32'(if_a.pass), 32'd1);
        check("t7_chk", 32'(if_a.check_count), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
